// File: rtl/spi_slave_sync.sv
// SPI slave (modes 0-3) bridged to valid/ready streams through rx/tx FIFOs, single clk domain.
// Words decode one clk after their last sample edge; streams stall only on FIFO full/empty.

module spi_slave_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_push_dat,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_pop   = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
   assign w_push  = i_push & (~w_full | w_pop);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push && !i_flush)
         r_mem[r_wr_ptr] <= i_push_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module spi_slave_sync #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 16,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             SCK,
   input  logic             MOSI,
   output logic             MISO,
   input  logic             SSEL,
   output logic [WIDTH-1:0] read_data,
   output logic             read_vld,
   input  logic             read_rdy,
   input  logic [WIDTH-1:0] write_data,
   input  logic             write_vld,
   output logic             write_rdy,
   output logic             spi_reset
);
   localparam int          CW          = $clog2(DEPTH) + 1;
   localparam int          BW          = $clog2(WIDTH);
   localparam logic        P_IDLE      = (CPOL != 0);
   localparam logic        SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
   localparam logic [63:0] MAXV        = (64'd1 << WIDTH) - 64'd1;
   localparam logic [WIDTH-1:0] OP_STATUS = WIDTH'(8'h81);
   localparam logic [WIDTH-1:0] OP_READ   = WIDTH'(8'h82);
   localparam logic [WIDTH-1:0] OP_WRITE  = WIDTH'(8'h04);
   localparam logic [WIDTH-1:0] OP_WR_RD  = WIDTH'(8'h86);
   localparam logic [WIDTH-1:0] OP_RESET  = WIDTH'(8'h08);

   typedef enum logic [2:0] {
      S_IDLE, S_STATUS0, S_STATUS1, S_STATUS2, S_READ, S_WRITE, S_WRITE_READ
   } state_t;

   function automatic logic [WIDTH-1:0] sat(input logic [CW-1:0] v);
      logic [63:0] v64;
      v64 = 64'(v);
      if (v64 > MAXV) return '1;
      return v64[WIDTH-1:0];
   endfunction

   logic [SYNC_STAGES-1:0] r_sck_sync, r_ssel_sync, r_mosi_sync;
   logic                   r_sck_d, r_ssel_d, r_active;
   logic                   w_sck, w_ssel, w_mosi, w_ssel_fall, w_sample, w_shift, w_load;
   logic [BW-1:0]          r_bit_cnt;
   logic [WIDTH-2:0]       r_rx_shift;
   logic [WIDTH-1:0]       r_rx_word, r_tx_shift;
   logic                   r_word_done, r_done_d;
   state_t                 r_state, w_state_nxt;
   logic [WIDTH-1:0]       w_load_word;
   logic                   w_tx_pop, w_rx_push, w_under_set, w_over_set, w_flag_clr, w_dec_reset;
   logic                   r_underflow, r_overflow, r_spi_reset;
   logic [WIDTH-1:0]       w_tx_head;
   logic [CW-1:0]          w_rx_count, w_tx_count;
   logic                   w_rx_empty, w_tx_empty, w_rx_full;

   assign w_sck       = r_sck_sync[SYNC_STAGES-1];
   assign w_ssel      = r_ssel_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_ssel_fall = r_ssel_d & ~w_ssel;
   assign w_sample    = r_active & (SAMPLE_RISE ? (w_sck & ~r_sck_d) : (~w_sck & r_sck_d));
   assign w_shift     = r_active & (SAMPLE_RISE ? (~w_sck & r_sck_d) : (w_sck & ~r_sck_d));
   // CPHA=1 presents each word on its leading shift edge; CPHA=0 preloads it right after the previous word decodes.
   assign w_load      = r_active & ((CPHA != 0) ? (w_shift & (r_bit_cnt == '0)) : r_done_d);

   // SSEL sync resets low so a select already held low at reset release is ignored until it toggles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sck_sync  <= {SYNC_STAGES{P_IDLE}};
         r_ssel_sync <= '0;
         r_mosi_sync <= '0;
         r_sck_d     <= P_IDLE;
         r_ssel_d    <= 1'b0;
         r_active    <= 1'b0;
      end else begin
         r_sck_sync  <= (r_sck_sync << 1) | SYNC_STAGES'(SCK);
         r_ssel_sync <= (r_ssel_sync << 1) | SYNC_STAGES'(SSEL);
         r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STAGES'(MOSI);
         r_sck_d     <= w_sck;
         r_ssel_d    <= w_ssel;
         if (w_ssel)           r_active <= 1'b0;
         else if (w_ssel_fall) r_active <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt   <= '0;
         r_rx_shift  <= '0;
         r_rx_word   <= '0;
         r_word_done <= 1'b0;
         r_done_d    <= 1'b0;
      end else begin
         r_word_done <= 1'b0;
         r_done_d    <= r_word_done;
         if (!r_active) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
         end else if (w_sample) begin
            r_rx_shift <= {r_rx_shift[WIDTH-3:0], w_mosi};
            if (r_bit_cnt == BW'(WIDTH-1)) begin
               r_bit_cnt   <= '0;
               r_rx_word   <= {r_rx_shift, w_mosi};
               r_word_done <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + BW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              r_tx_shift <= '0;
      else if (!r_active)                     r_tx_shift <= '0;
      else if (w_load)                        r_tx_shift <= w_load_word;
      else if (w_shift && r_bit_cnt != '0)    r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_word = '0;
      w_tx_pop    = 1'b0;
      w_rx_push   = 1'b0;
      w_under_set = 1'b0;
      w_flag_clr  = 1'b0;
      w_dec_reset = 1'b0;
      if (r_word_done) begin
         case (r_state)
            S_IDLE: begin
               if      (r_rx_word == OP_STATUS) w_state_nxt = S_STATUS0;
               else if (r_rx_word == OP_READ)   w_state_nxt = S_READ;
               else if (r_rx_word == OP_WRITE)  w_state_nxt = S_WRITE;
               else if (r_rx_word == OP_WR_RD)  w_state_nxt = S_WRITE_READ;
               else if (r_rx_word == OP_RESET)  w_dec_reset = 1'b1;
            end
            S_WRITE, S_WRITE_READ: w_rx_push = 1'b1;
            default: ;
         endcase
      end
      if (w_load) begin
         case (r_state)
            S_STATUS0: begin
               w_load_word = sat(CW'(DEPTH) - w_rx_count);
               w_state_nxt = S_STATUS1;
            end
            S_STATUS1: begin
               w_load_word = sat(w_tx_count);
               w_state_nxt = S_STATUS2;
            end
            S_STATUS2: begin
               w_load_word = WIDTH'({r_underflow, r_overflow});
               w_flag_clr  = 1'b1;
               w_state_nxt = S_IDLE;
            end
            S_READ, S_WRITE_READ: begin
               if (!w_tx_empty) begin
                  w_load_word = w_tx_head;
                  w_tx_pop    = 1'b1;
               end else begin
                  w_under_set = 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (!r_active) w_state_nxt = S_IDLE;
   end

   // A full rx FIFO is not empty, so read_rdy alone tells whether a slot frees this cycle.
   assign w_rx_full  = (w_rx_count == CW'(DEPTH));
   assign w_over_set = w_rx_push & w_rx_full & ~read_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
         r_spi_reset <= 1'b0;
      end else begin
         r_underflow <= (r_underflow & ~w_flag_clr) | w_under_set;
         r_overflow  <= (r_overflow & ~w_flag_clr) | w_over_set;
         r_spi_reset <= w_dec_reset;
      end
   end

   spi_slave_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (w_dec_reset),
      .i_push     (w_rx_push),
      .i_push_dat (r_rx_word),
      .i_pop      (read_rdy),
      .o_head     (read_data),
      .o_count    (w_rx_count),
      .o_empty    (w_rx_empty)
   );

   spi_slave_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (w_dec_reset),
      .i_push     (write_vld),
      .i_push_dat (write_data),
      .i_pop      (w_tx_pop),
      .o_head     (w_tx_head),
      .o_count    (w_tx_count),
      .o_empty    (w_tx_empty)
   );

   assign MISO      = r_tx_shift[WIDTH-1];
   assign read_vld  = ~w_rx_empty;
   assign write_rdy = (w_tx_count != CW'(DEPTH));
   assign spi_reset = r_spi_reset;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: one instance per SPI mode, index = {CPOL, CPHA}.
module tb_spi_slave_sync;
   localparam int HALF = 50;

   logic       clk;
   logic       reset;
   logic       sck      [4];
   logic       mosi     [4];
   logic       miso     [4];
   logic       ssel     [4];
   logic [7:0] rd_dat   [4];
   logic       rd_vld   [4];
   logic       rd_rdy   [4];
   logic [7:0] wr_dat   [4];
   logic       wr_vld   [4];
   logic       wr_rdy   [4];
   logic       spi_rst  [4];

   logic [7:0] tb_tx [32];
   logic [7:0] tb_rx [32];
   int n_chk = 0;
   int n_err = 0;
   int rst_pulses = 0;
   logic rst_prev = 1'b0;
   logic rv_after = 1'b1;
   logic wr_after = 1'b0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_sync #(.WIDTH(8), .DEPTH(16), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .SCK        (sck[g]),
         .MOSI       (mosi[g]),
         .MISO       (miso[g]),
         .SSEL       (ssel[g]),
         .read_data  (rd_dat[g]),
         .read_vld   (rd_vld[g]),
         .read_rdy   (rd_rdy[g]),
         .write_data (wr_dat[g]),
         .write_vld  (wr_vld[g]),
         .write_rdy  (wr_rdy[g]),
         .spi_reset  (spi_rst[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (spi_rst[0]) rst_pulses++;
      if (rst_prev) begin
         rv_after = rd_vld[0];
         wr_after = wr_rdy[0];
      end
      rst_prev = spi_rst[0];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Master side: n words from tb_tx, last word truncated to last_bits; MISO captured into tb_rx.
   task automatic spi_xact(input int m, input int n, input int last_bits);
      logic cp, ch;
      cp = ((m / 2) != 0);
      ch = ((m % 2) != 0);
      ssel[m] = 1'b0;
      #(2 * HALF);
      for (int w = 0; w < n; w++) begin
         int nb;
         nb = (w == n - 1) ? last_bits : 8;
         tb_rx[w] = 8'h00;
         for (int b = 0; b < nb; b++) begin
            if (!ch) begin
               mosi[m] = tb_tx[w][7 - b];
               #HALF;
               tb_rx[w][7 - b] = miso[m];
               sck[m] = ~cp;
               #HALF;
               sck[m] = cp;
            end else begin
               sck[m] = ~cp;
               mosi[m] = tb_tx[w][7 - b];
               #HALF;
               tb_rx[w][7 - b] = miso[m];
               sck[m] = cp;
               #HALF;
            end
         end
      end
      #HALF;
      ssel[m] = 1'b1;
      #(4 * HALF);
   endtask

   task automatic push_tx(input int m, input logic [7:0] d);
      @(negedge clk);
      wr_dat[m] = d;
      wr_vld[m] = 1'b1;
      @(negedge clk);
      wr_vld[m] = 1'b0;
   endtask

   task automatic read_one(input int m, input logic [7:0] exp, input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (rd_vld[m]) got = 1'b1;
      end
      chk({tag, "_vld"}, 32'(got), 32'd1);
      if (got) begin
         chk(tag, 32'(rd_dat[m]), 32'(exp));
         rd_rdy[m] = 1'b1;
         @(negedge clk);
         rd_rdy[m] = 1'b0;
      end
   endtask

   task automatic do_status(input int m, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input string tag);
      tb_tx[0] = 8'h81;
      tb_tx[1] = 8'h00;
      tb_tx[2] = 8'h00;
      tb_tx[3] = 8'h00;
      spi_xact(m, 4, 8);
      chk({tag, "_w1"}, 32'(tb_rx[1]), 32'(e1));
      chk({tag, "_w2"}, 32'(tb_rx[2]), 32'(e2));
      chk({tag, "_w3"}, 32'(tb_rx[3]), 32'(e3));
   endtask

   initial begin
      reset = 1'b0;
      for (int m = 0; m < 4; m++) begin
         sck[m]    = ((m / 2) != 0);
         ssel[m]   = 1'b1;
         mosi[m]   = 1'b0;
         rd_rdy[m] = 1'b0;
         wr_vld[m] = 1'b0;
         wr_dat[m] = 8'h00;
      end
      #3 reset = 1'b1;
      #1;
      chk("rst_miso", 32'(miso[0]), 32'd0);
      chk("rst_spi_reset", 32'(spi_rst[0]), 32'd0);
      for (int m = 0; m < 4; m++) chk($sformatf("rst_read_vld_m%0d", m), 32'(rd_vld[m]), 32'd0);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int m = 0; m < 4; m++) chk($sformatf("write_rdy_m%0d", m), 32'(wr_rdy[m]), 32'd1);

      // Mode 0 WRITE of two words
      tb_tx[0] = 8'h04; tb_tx[1] = 8'hA5; tb_tx[2] = 8'h3C;
      spi_xact(0, 3, 8);
      read_one(0, 8'hA5, "write_w1");
      read_one(0, 8'h3C, "write_w2");
      repeat (4) @(negedge clk);
      chk("write_drained", 32'(rd_vld[0]), 32'd0);

      // READ past the end of tx data returns zero and flags underflow
      push_tx(0, 8'h11);
      push_tx(0, 8'h22);
      tb_tx[0] = 8'h82; tb_tx[1] = 8'h00; tb_tx[2] = 8'h00; tb_tx[3] = 8'h00;
      spi_xact(0, 4, 8);
      chk("read_w1", 32'(tb_rx[1]), 32'h11);
      chk("read_w2", 32'(tb_rx[2]), 32'h22);
      chk("read_w3", 32'(tb_rx[3]), 32'h00);
      do_status(0, 8'h10, 8'h00, 8'h02, "stat_under");
      do_status(0, 8'h10, 8'h00, 8'h00, "stat_cleared");

      // Overflow: 17 words into a 16-deep rx FIFO with no reader
      tb_tx[0] = 8'h04;
      for (int i = 1; i <= 17; i++) tb_tx[i] = 8'h40 + 8'(i - 1);
      spi_xact(0, 18, 8);
      chk("ovf_read_vld", 32'(rd_vld[0]), 32'd1);
      do_status(0, 8'h00, 8'h00, 8'h01, "stat_over");
      do_status(0, 8'h00, 8'h00, 8'h00, "stat_over_clr");
      for (int i = 0; i < 16; i++) read_one(0, 8'h40 + 8'(i), $sformatf("ovf_rd%0d", i));
      repeat (4) @(negedge clk);
      chk("ovf_drained", 32'(rd_vld[0]), 32'd0);

      // Partial word at SSEL rise is discarded
      tb_tx[0] = 8'h04; tb_tx[1] = 8'h77;
      spi_xact(0, 2, 5);
      repeat (20) @(negedge clk);
      chk("partial_no_push", 32'(rd_vld[0]), 32'd0);
      tb_tx[1] = 8'h99;
      spi_xact(0, 2, 8);
      read_one(0, 8'h99, "after_partial");

      // RESET opcode with both FIFOs holding data
      push_tx(0, 8'h55);
      tb_tx[0] = 8'h04; tb_tx[1] = 8'h66;
      spi_xact(0, 2, 8);
      chk("pre_reset_vld", 32'(rd_vld[0]), 32'd1);
      rst_pulses = 0;
      tb_tx[0] = 8'h08;
      spi_xact(0, 1, 8);
      chk("spi_reset_pulses", 32'(rst_pulses), 32'd1);
      chk("reset_read_vld", 32'(rv_after), 32'd0);
      chk("reset_write_rdy", 32'(wr_after), 32'd1);
      do_status(0, 8'h10, 8'h00, 8'h00, "stat_after_reset");

      // WRITE_READ in modes 1..3
      for (int m = 1; m < 4; m++) begin
         push_tx(m, 8'hC3);
         tb_tx[0] = 8'h86; tb_tx[1] = 8'h5A;
         spi_xact(m, 2, 8);
         chk($sformatf("wr_rd_miso_m%0d", m), 32'(tb_rx[1]), 32'hC3);
         read_one(m, 8'h5A, $sformatf("wr_rd_rx_m%0d", m));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
